// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Outputs feed the ALU directly; control bits continue on to EX/MEM.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [CONTROL_WIDTH-1:0] id_ALUCtrl,
  input  logic [4:0]               id_Shamt,
  input  logic [4:0]               id_rs,
  input  logic [4:0]               id_rt,
  input  logic [4:0]               id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs_data,
  input  logic [DATA_WIDTH-1:0]    id_rt_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_ALUSrc,
  input  logic                     id_uses_rt,
  input  logic                     id_RegWrite,
  input  logic                     id_MemRead,
  input  logic                     id_MemWrite,
  input  logic                     id_MemtoReg,
  input  logic                     flush,
  input  logic                     hold,
  input  logic                     exmem_RegWrite,
  input  logic [4:0]               exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_RegWrite,
  input  logic [4:0]               memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_wdata,
  output logic [CONTROL_WIDTH-1:0] ALUCtrl,
  output logic [4:0]               Shamt,
  output logic [DATA_WIDTH-1:0]    A,
  output logic [DATA_WIDTH-1:0]    B,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic [4:0]               ex_rd,
  output logic                     ex_RegWrite,
  output logic                     ex_MemRead,
  output logic                     ex_MemWrite,
  output logic                     ex_MemtoReg,
  output logic                     stall_id,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                     r_valid;
  logic [CONTROL_WIDTH-1:0] r_alu_ctrl;
  logic                     r_reg_write;
  logic                     r_mem_read;
  logic                     r_mem_write;
  logic                     r_mem_to_reg;
  logic [4:0]               r_shamt;
  logic [4:0]               r_rs;
  logic [4:0]               r_rt;
  logic [4:0]               r_rd;
  logic [DATA_WIDTH-1:0]    r_rs_data;
  logic [DATA_WIDTH-1:0]    r_rt_data;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic                     r_alu_src;
  logic [CNT_WIDTH-1:0]     r_stall_cnt;
  logic [CNT_WIDTH-1:0]     r_flush_cnt;

  logic                     w_load_use;
  logic                     w_bubble;
  logic                     w_load;
  logic [4:0]               w_src_reg  [2];
  logic [DATA_WIDTH-1:0]    w_src_data [2];
  logic [DATA_WIDTH-1:0]    w_fwd      [2];
  logic [1:0]               w_ex_hit;
  logic [1:0]               w_wb_hit;

  // The instruction in EX is a load whose result the decoding instruction needs now.
  assign w_load_use = r_valid && r_mem_read && (r_rd != 5'd0) && id_valid &&
                      ((id_rs == r_rd) || (id_uses_rt && (id_rt == r_rd)));
  assign w_bubble   = !hold && (flush || w_load_use);
  assign w_load     = !hold && !flush && !w_load_use;
  assign stall_id   = w_load_use && !flush;

  // Control half: a bubble clears it so nothing downstream acts on a squashed slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_alu_ctrl   <= '1;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_alu_ctrl   <= '1;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_load) begin
      r_valid      <= id_valid;
      r_alu_ctrl   <= id_ALUCtrl;
      r_reg_write  <= id_RegWrite;
      r_mem_read   <= id_MemRead;
      r_mem_write  <= id_MemWrite;
      r_mem_to_reg <= id_MemtoReg;
    end
  end

  // Data half is left alone on a bubble; its contents are meaningless while r_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shamt   <= 5'd0;
      r_rs      <= 5'd0;
      r_rt      <= 5'd0;
      r_rd      <= 5'd0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_alu_src <= 1'b0;
    end else if (w_load) begin
      r_shamt   <= id_Shamt;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_alu_src <= id_ALUSrc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hold) begin
      if (flush) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else if (w_load_use) begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign w_src_reg[0]  = r_rs;
  assign w_src_reg[1]  = r_rt;
  assign w_src_data[0] = r_rs_data;
  assign w_src_data[1] = r_rt_data;

  // One forwarding mux per source operand; the younger EX/MEM value beats MEM/WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign w_ex_hit[gi] = exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == w_src_reg[gi]);
    assign w_wb_hit[gi] = memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == w_src_reg[gi]);
    assign w_fwd[gi]    = w_ex_hit[gi] ? exmem_result :
                          w_wb_hit[gi] ? memwb_wdata  : w_src_data[gi];
  end

  assign ALUCtrl       = r_alu_ctrl;
  assign Shamt         = r_shamt;
  assign A             = w_fwd[0];
  assign B             = r_alu_src ? r_imm : w_fwd[1];
  assign ex_store_data = w_fwd[1];
  assign ex_valid      = r_valid;
  assign ex_rd         = r_rd;
  assign ex_RegWrite   = r_reg_write;
  assign ex_MemRead    = r_mem_read;
  assign ex_MemWrite   = r_mem_write;
  assign ex_MemtoReg   = r_mem_to_reg;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule
